// File: rtl/fifo_stream_drain_if.sv
// fifo_stream_drain_if: FIFO read port plus valid/ready stream bundle for fifo_stream_drain
interface fifo_stream_drain_if #(parameter int DATA_WIDTH = 8);
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  modport master (
    input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );
  modport slave (
    output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: FIFO read port to packetised stream via 2-entry skid; FIFO_DRAIN_STATS_EN adds beat/stall counters
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int PKTCNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_stream_drain_if.master   bus,
  output logic [PKTCNT_W-1:0]   pkt_count,
  output logic                  err_underflow
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_d0, r_d1;
  logic [1:0]            r_cnt, w_cnt_n;
  logic                  r_pend;
  logic [BW-1:0]         r_beat;
  logic                  w_pop, w_rd;
  logic [2:0]            w_occ;
  // credit counts the word already requested from the FIFO so the skid can never overflow
  assign w_occ   = {1'b0, r_cnt} + {2'b0, r_pend};
  assign w_pop   = bus.m_valid && bus.m_ready;
  assign w_rd    = !rst && !bus.fifo_empty && (w_occ - {2'b0, w_pop} < 3'd2);
  assign w_cnt_n = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign bus.fifo_rd_en = w_rd;
  assign bus.m_valid    = !rst && r_cnt != 2'd0;
  assign bus.m_data     = rst ? '0 : r_d0;
  assign bus.m_last     = bus.m_valid && r_beat == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 2'd0;
      r_pend        <= 1'b0;
      r_beat        <= '0;
      r_d0          <= '0;
      r_d1          <= '0;
      pkt_count     <= '0;
      err_underflow <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_pend <= w_rd;
      r_d0   <= w_pop ? (r_cnt == 2'd2 ? r_d1 : bus.fifo_data_out)
                      : (r_cnt == 2'd0 ? bus.fifo_data_out : r_d0);
      if (r_pend && (w_pop ? r_cnt == 2'd2 : r_cnt == 2'd1))
        r_d1 <= bus.fifo_data_out;
      if (w_pop) begin
        r_beat <= r_beat == LAST ? '0 : r_beat + BW'(1);
        if (r_beat == LAST)
          pkt_count <= pkt_count + PKTCNT_W'(1);
      end
      if (bus.fifo_underflow)
        err_underflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_n;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = w_rd ? FETCH : IDLE;
      FETCH:   w_state_n = w_cnt_n == 2'd2 ? HOLD : (w_cnt_n == 2'd0 && !w_rd) ? IDLE : FETCH;
      HOLD:    w_state_n = w_pop ? FETCH : HOLD;
      default: w_state_n = IDLE;
    endcase
  end
`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_pop)
        beat_cnt <= beat_cnt + 32'd1;
      if (bus.m_valid && !bus.m_ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
